mod_addsub_pipe: RTL

- Pipelined, multi-lane modular adder/subtractor for the NTT datapath.
- Each accepted beat applies one operation to all lanes:
  - add: C = (A + B) mod M
  - subtract: C = (A − B) mod M
- Successor to the combinational modular adder. Adds subtract mode, lane parallelism, registered stages, valid/ready backpressure and tag passthrough.
- Sits between the coefficient memories and the butterfly/post-processing stages.

---
 rtl/mod_addsub_pipe_pkg.sv | 14 +
 rtl/mod_addsub_lane.sv | 69 ++++++
 rtl/mod_addsub_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/mod_addsub_pipe_pkg.sv
// Shared NTT datapath definitions: operation encodings and lane packing helper.
package mod_addsub_pipe_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   // LSB position of lane `lane` in a packed vector of k-bit lanes.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned k);
      return lane * k;
   endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// One coefficient lane: S1 forms the raw sum/difference, S2 reduces it modulo M.
module mod_addsub_lane
   import mod_addsub_pipe_pkg::*;
#(
   parameter int unsigned K = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s1_en,
   input  logic         s2_en,
   input  logic         mode,
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         s1_mode,
   input  logic [K-1:0] s1_mod,
   output logic [K-1:0] c
);

   localparam int unsigned W = K + 2;

   logic        [W-1:0] raw_d;
   logic        [W-1:0] raw_q;
   logic signed [W-1:0] raw_s;
   logic signed [W-1:0] m_s;
   logic signed [W-1:0] t2;
   logic signed [W-1:0] t3;
   logic signed [W-1:0] sel;
   logic        [K-1:0] c_d;

   // Two guard bits hold both the K+1 bit sum and the signed difference.
   always_comb begin
      raw_d = W'(a) + W'(b);
      if (mode_e'(mode) == MODE_SUB) begin
         raw_d = W'(a) - W'(b);
      end
   end

   always_ff @(posedge clk) begin
      if (s1_en) begin
         raw_q <= raw_d;
      end
   end

   // Reduction: sign bits of the candidates pick the result, truncation happens last.
   always_comb begin
      raw_s = $signed(raw_q);
      m_s   = $signed(W'(s1_mod));
      t2    = raw_s - m_s;
      t3    = raw_s - m_s - m_s;
      sel   = raw_s;
      if (mode_e'(s1_mode) == MODE_SUB) begin
         if (raw_s[W-1]) begin
            sel = raw_s + m_s;
         end
      end else if (!t2[W-1]) begin
         sel = t3[W-1] ? t2 : t3;
      end
      c_d = (s1_mod == '0) ? '0 : K'(sel);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c <= '0;
      end else if (s2_en) begin
         c <= c_d;
      end
   end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage multi-lane modular add/subtract with valid/ready flow control and tag passthrough.
module mod_addsub_pipe
   import mod_addsub_pipe_pkg::*;
#(
   parameter int unsigned K     = 8,
   parameter int unsigned LANES = 1,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic [LANES*K-1:0]   in_a,
   input  logic [LANES*K-1:0]   in_b,
   input  logic [K-1:0]         in_mod,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*K-1:0]   out_c,
   output logic [TAG_W-1:0]     out_tag
);

   logic             s1_valid;
   logic             s2_valid;
   logic             s1_adv;
   logic             s2_adv;
   logic             s1_load;
   logic             s2_load;
   logic             s1_mode;
   logic [K-1:0]     s1_mod;
   logic [TAG_W-1:0] s1_tag;

   // A stage may take new data when it is empty or its content moves on this cycle.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign s1_load   = in_valid && s1_adv;
   assign s2_load   = s1_valid && s2_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
         end
      end
   end

   // Mode, modulus and tag ride with the beat so consecutive beats stay independent.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_mode <= in_mode;
         s1_mod  <= in_mod;
         s1_tag  <= in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_tag <= '0;
      end else if (s2_load) begin
         out_tag <= s1_tag;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mod_addsub_lane #(
         .K (K)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .s1_en   (s1_load),
         .s2_en   (s2_load),
         .mode    (in_mode),
         .a       (in_a[lane_lsb(i, K) +: K]),
         .b       (in_b[lane_lsb(i, K) +: K]),
         .s1_mode (s1_mode),
         .s1_mod  (s1_mod),
         .c       (out_c[lane_lsb(i, K) +: K])
      );
   end

endmodule
